// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 8x8 unsigned shift-add multiplier that borrows the shared ALU
// through a request/grant pair, one ADD and one LSR per multiplier bit.
module alu_mul_seq #(
    parameter logic [8:0] OP_ADD = 9'h000,
    parameter logic [8:0] OP_LSR = 9'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [7:0]  mcand_i,
    input  logic [7:0]  mplier_i,
    input  logic        alu_gnt_i,
    output logic        alu_req_o,
    output logic [8:0]  alu_op_o,
    output logic [7:0]  alu_rs_o,
    output logic [7:0]  alu_rt_o,
    input  logic [7:0]  alu_result_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] product_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_mcand, r_hi, r_lo;
    logic       r_c;
    logic [3:0] r_cnt;
    logic       w_add, w_shf;

    always_comb begin
        w_add     = r_state == S_ADD;
        w_shf     = r_state == S_SHIFT;
        alu_req_o = w_add | w_shf;
        alu_op_o  = w_add ? OP_ADD : w_shf ? OP_LSR : 9'h000;
        alu_rs_o  = (w_add | w_shf) ? r_hi : 8'h00;
        alu_rt_o  = w_add ? (r_lo[0] ? r_mcand : 8'h00) : w_shf ? 8'h01 : 8'h00;
        busy_o    = r_state != S_IDLE;
        done_o    = r_state == S_DONE;
        product_o = {r_hi, r_lo};
    end

    // The ALU carry is not used; a wrapped sum is detected by result < hi.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mcand <= 8'h00;
            r_hi    <= 8'h00;
            r_lo    <= 8'h00;
            r_c     <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_mcand <= mcand_i;
                    r_hi    <= 8'h00;
                    r_lo    <= mplier_i;
                    r_cnt   <= 4'd8;
                    r_state <= S_ADD;
                end
                S_ADD: if (alu_gnt_i) begin
                    r_hi    <= alu_result_i;
                    r_c     <= alu_result_i < r_hi;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: if (alu_gnt_i) begin
                    r_hi    <= alu_result_i | {r_c, 7'b0};
                    r_lo    <= {r_hi[0], r_lo[7:1]};
                    r_c     <= 1'b0;
                    r_cnt   <= r_cnt - 4'd1;
                    r_state <= (r_cnt == 4'd1) ? S_DONE : S_ADD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed multiplies against a behavioural ALU, with a
// product scoreboard and per-cycle checks of request, op order and stall freeze.
module tb_alu_mul_seq;
    localparam logic [8:0] P_ADD = 9'h002;
    localparam logic [8:0] P_LSR = 9'h01C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  mcand_i = 8'h00;
    logic [7:0]  mplier_i = 8'h00;
    logic        alu_gnt_i = 1'b1;
    logic        alu_req_o;
    logic [8:0]  alu_op_o;
    logic [7:0]  alu_rs_o;
    logic [7:0]  alu_rt_o;
    logic [7:0]  alu_result_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] product_o;

    int          total = 0;
    int          passed = 0;
    logic [15:0] sb[$];
    logic [15:0] tmp;

    alu_mul_seq #(.OP_ADD(P_ADD), .OP_LSR(P_LSR)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .mcand_i(mcand_i),
        .mplier_i(mplier_i), .alu_gnt_i(alu_gnt_i), .alu_req_o(alu_req_o),
        .alu_op_o(alu_op_o), .alu_rs_o(alu_rs_o), .alu_rt_o(alu_rt_o),
        .alu_result_i(alu_result_i), .busy_o(busy_o), .done_o(done_o),
        .product_o(product_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result_i = 8'h00;
        if (alu_op_o == P_ADD) alu_result_i = alu_rs_o + alu_rt_o;
        else if (alu_op_o == P_LSR) alu_result_i = alu_rs_o >> alu_rt_o;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // smask bit n drops the grant for the cycle observed at negedge n after start.
    task automatic run_mul(input string tag, input logic [7:0] mc, input logic [7:0] mp,
                           input logic [63:0] smask, input int lat, input bit hold, input bit zrt);
        int n;
        int reqs;
        bit stalled;
        logic [8:0] eop;
        logic [25:0] saved;
        @(negedge clk);
        start_i = 1'b1; mcand_i = mc; mplier_i = mp; alu_gnt_i = 1'b1;
        sb.push_back(16'(mc) * 16'(mp));
        n = 0; reqs = 0; stalled = 0; eop = P_ADD; saved = '0;
        do begin
            @(negedge clk);
            n++;
            if (!hold) start_i = 1'b0;
            if (hold && n == 6) begin mcand_i = 8'hFF; mplier_i = 8'hFF; end
            if (stalled) check({tag, ":freeze"}, 32'({alu_op_o, alu_rs_o, alu_rt_o, alu_req_o}), 32'(saved));
            if (alu_req_o) begin
                reqs++;
                check({tag, ":op"}, 32'(alu_op_o), 32'(eop));
                if (zrt && alu_op_o == P_ADD) check({tag, ":rt0"}, 32'(alu_rt_o), 32'h0);
            end
            alu_gnt_i = !smask[n];
            stalled = alu_req_o && !alu_gnt_i;
            saved = {alu_op_o, alu_rs_o, alu_rt_o, alu_req_o};
            if (alu_req_o && alu_gnt_i) eop = (eop == P_ADD) ? P_LSR : P_ADD;
        end while (!done_o && n < 60);
        alu_gnt_i = 1'b1;
        check({tag, ":latency"}, 32'(n), 32'(lat));
        check({tag, ":done"}, 32'(done_o), 32'h1);
        check({tag, ":busy_done"}, 32'(busy_o), 32'h1);
        check({tag, ":reqs"}, 32'(reqs), 32'(lat - 1));
        tmp = (sb.size() != 0) ? sb.pop_front() : 16'hDEAD;
        check({tag, ":product"}, 32'(product_o), 32'(tmp));
        @(negedge clk);
        check({tag, ":pulse"}, 32'(done_o), 32'h0);
        check({tag, ":idle"}, 32'(busy_o), 32'h0);
        start_i = 1'b0;
        @(negedge clk);
        check({tag, ":no_restart"}, 32'(busy_o), 32'h0);
        check({tag, ":hold_prod"}, 32'(product_o), 32'(tmp));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst:busy", 32'(busy_o), 32'h0);
        check("rst:done", 32'(done_o), 32'h0);
        check("rst:req", 32'(alu_req_o), 32'h0);
        check("rst:ops", 32'({alu_op_o, alu_rs_o, alu_rt_o}), 32'h0);
        check("rst:product", 32'(product_o), 32'h0);
        reset = 1'b0;
        run_mul("13x11", 8'd13, 8'd11, 64'h0, 17, 1'b0, 1'b0);
        check("13x11:value", 32'(product_o), 32'h008F);
        run_mul("ffxff", 8'hFF, 8'hFF, 64'h0, 17, 1'b0, 1'b0);
        check("ffxff:value", 32'(product_o), 32'hFE01);
        run_mul("a5x0", 8'hA5, 8'h00, 64'h0, 17, 1'b0, 1'b1);
        run_mul("0xa5", 8'h00, 8'hA5, 64'h0, 17, 1'b0, 1'b0);
        check("0xa5:value", 32'(product_o), 32'h0);
        run_mul("7x9stall", 8'd7, 8'd9, 64'h1B8, 22, 1'b0, 1'b0);
        check("7x9stall:value", 32'(product_o), 32'h003F);
        run_mul("3x5hold", 8'd3, 8'd5, 64'h0, 17, 1'b1, 1'b0);
        check("3x5hold:value", 32'(product_o), 32'h000F);
        @(negedge clk);
        start_i = 1'b1; mcand_i = 8'd9; mplier_i = 8'd9;
        sb.push_back(16'd81);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        check("rstmid:in_shift", 32'(alu_op_o), 32'(P_LSR));
        reset = 1'b1;
        tmp = sb.pop_front();
        @(negedge clk);
        reset = 1'b0;
        check("rstmid:busy", 32'(busy_o), 32'h0);
        check("rstmid:req", 32'(alu_req_o), 32'h0);
        check("rstmid:done", 32'(done_o), 32'h0);
        check("rstmid:product", 32'(product_o), 32'h0);
        run_mul("2x3", 8'd2, 8'd3, 64'h0, 17, 1'b0, 1'b0);
        check("2x3:value", 32'(product_o), 32'h0006);
        check("sb:empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
